// File: rtl/aes_pkg.sv
// Shared definitions for the iterative AES encryption core: FSM encoding,
// round-count derivation, block/index widths and the byte-level cipher helpers.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int RK_IDX_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_DONE  = 2'd3
  } aes_state_e;

  // Returns 0 for an unsupported key length so the core can refuse to elaborate.
  function automatic int nr_of(input int key_bits);
    case (key_bits)
      128:     return 10;
      192:     return 12;
      256:     return 14;
      default: return 0;
    endcase
  endfunction

  // S-box as one flat constant; entry b occupies bits [8b +: 8] of an ascending range.
  localparam logic [0:2047] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[{b, 3'b000} +: 8];
  endfunction

  // Multiply by x in GF(2^8) modulo 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_enc_round.sv
// One combinational AES encryption round: SubBytes, ShiftRows, optional MixColumns,
// AddRoundKey. Byte i of the block sits at bits [127-8i -: 8], row i%4, column i/4.
module aes_enc_round
  import aes_pkg::*;
(
  input  logic [AES_BLOCK_W-1:0] state_in,
  input  logic [AES_BLOCK_W-1:0] rk,
  input  logic                   last_round,
  output logic [AES_BLOCK_W-1:0] state_out
);

  logic [7:0] sb [16];
  logic [7:0] sr [16];
  logic [7:0] mc [16];
  logic [AES_BLOCK_W-1:0] mixed;

  for (genvar gi = 0; gi < 16; gi++) begin : g_byte
    assign sb[gi] = sbox(state_in[AES_BLOCK_W-1-8*gi -: 8]);
    // Row r rotates left by r columns.
    assign sr[gi] = sb[(gi % 4) + 4 * (((gi / 4) + (gi % 4)) % 4)];
    assign mixed[AES_BLOCK_W-1-8*gi -: 8] = last_round ? sr[gi] : mc[gi];
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_col
    assign mc[4*gi+0] = xtime(sr[4*gi+0]) ^ xtime(sr[4*gi+1]) ^ sr[4*gi+1] ^ sr[4*gi+2] ^ sr[4*gi+3];
    assign mc[4*gi+1] = sr[4*gi+0] ^ xtime(sr[4*gi+1]) ^ xtime(sr[4*gi+2]) ^ sr[4*gi+2] ^ sr[4*gi+3];
    assign mc[4*gi+2] = sr[4*gi+0] ^ sr[4*gi+1] ^ xtime(sr[4*gi+2]) ^ xtime(sr[4*gi+3]) ^ sr[4*gi+3];
    assign mc[4*gi+3] = xtime(sr[4*gi+0]) ^ sr[4*gi+0] ^ sr[4*gi+1] ^ sr[4*gi+2] ^ xtime(sr[4*gi+3]);
  end

  assign state_out = mixed ^ rk;

endmodule

// File: rtl/aes_enc_iter_core.sv
// Iterative AES encryptor: one round per clock through a single shared round
// datapath, with valid/ready on both sides, back-to-back loading and flush.
module aes_enc_iter_core
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_BLOCK_W-1:0] pt_in,
  input  logic [AES_BLOCK_W-1:0] rk_in,
  output logic [RK_IDX_W-1:0]    rk_idx_out,
  input  logic                   flush_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_BLOCK_W-1:0] ct_out,
  output logic                   busy_out
);

  localparam int NR = nr_of(KEY_BITS);
  localparam logic [RK_IDX_W-1:0] NR_IDX     = RK_IDX_W'(NR);
  localparam logic [RK_IDX_W-1:0] PENULT_IDX = RK_IDX_W'(NR - 1);

  if (NR == 0) begin : g_bad_key_bits
    $error("aes_enc_iter_core: KEY_BITS must be 128, 192 or 256");
  end

  aes_state_e             state;
  logic [RK_IDX_W-1:0]    round_cnt;
  logic [AES_BLOCK_W-1:0] state_q;
  logic [AES_BLOCK_W-1:0] round_out;
  logic                   last_round;
  logic                   accept;

  assign last_round = (state == ST_FINAL);

  aes_enc_round u_round (
    .state_in  (state_q),
    .rk        (rk_in),
    .last_round(last_round),
    .state_out (round_out)
  );

  // The key store answers combinationally, so the index is decoded straight from state.
  always_comb begin
    rk_idx_out = '0;
    case (state)
      ST_ROUND: rk_idx_out = round_cnt;
      ST_FINAL: rk_idx_out = NR_IDX;
      default:  rk_idx_out = '0;
    endcase
  end

  assign in_ready  = !flush_in && ((state == ST_IDLE) || (state == ST_DONE && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == ST_DONE);
  assign busy_out  = (state != ST_IDLE);
  assign ct_out    = out_valid ? state_q : '0;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      round_cnt <= '0;
      state_q   <= '0;
    end else if (flush_in) begin
      state     <= ST_IDLE;
      round_cnt <= '0;
      state_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state_q   <= pt_in ^ rk_in;
            round_cnt <= RK_IDX_W'(1);
            state     <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          state_q   <= round_out;
          round_cnt <= round_cnt + RK_IDX_W'(1);
          if (round_cnt == PENULT_IDX) state <= ST_FINAL;
        end
        ST_FINAL: begin
          state_q   <= round_out;
          round_cnt <= '0;
          state     <= ST_DONE;
        end
        ST_DONE: begin
          // A new block can ride on the same cycle as the output handshake.
          if (accept) begin
            state_q   <= pt_in ^ rk_in;
            round_cnt <= RK_IDX_W'(1);
            state     <= ST_ROUND;
          end else if (out_ready) begin
            state_q <= '0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_enc_iter_core.sv
// Directed bench for aes_enc_iter_core: one DUT per key length, round keys from a
// bench-side key expansion, expected ciphertexts from known vectors or a byte-level model.
module tb_aes_enc_iter_core;

  localparam logic [127:0] PT0    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         out_ready;
  logic [127:0] pt;
  logic [2:0]   in_valid_v;
  logic [2:0]   in_ready_v;
  logic [2:0]   out_valid_v;
  logic [2:0]   busy_v;
  logic [127:0] rk_a     [3];
  logic [3:0]   rk_idx_a [3];
  logic [127:0] ct_a     [3];
  logic [127:0] rk_tab   [3][16];
  logic [7:0]   sb       [256];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    aes_enc_iter_core #(.KEY_BITS(128 + 64 * gi)) u_dut (
      .CLK       (clk),
      .RST       (rst),
      .in_valid  (in_valid_v[gi]),
      .in_ready  (in_ready_v[gi]),
      .pt_in     (pt),
      .rk_in     (rk_a[gi]),
      .rk_idx_out(rk_idx_a[gi]),
      .flush_in  (flush),
      .out_valid (out_valid_v[gi]),
      .out_ready (out_ready),
      .ct_out    (ct_a[gi]),
      .busy_out  (busy_v[gi])
    );
    assign rk_a[gi] = rk_tab[gi][rk_idx_a[gi]];
  end

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
  endfunction

  // Round key r of an nk-word key (key left-aligned in 256 bits).
  function automatic logic [127:0] rk_of(input int nk, input logic [255:0] key, input int r);
    logic [31:0] w [60];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (r + 1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        tmp = subw(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] aes_ref(input int k, input logic [127:0] p);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] v;
    int nr = 10 + 2 * k;
    v = p ^ rk_tab[k][0];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sb[v[127-8*i -: 8]];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) t[w + 4*c] = s[w + 4*((c + w) % 4)];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (r < nr) begin
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) v[127-8*i -: 8] = s[i];
      v = v ^ rk_tab[k][r];
    end
    return v;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one block to DUT k, measure accept-to-out_valid latency, check ct and handshake.
  task automatic send_block(input int k, input logic [127:0] p, input logic [127:0] e,
                            input int lat, input string tag);
    int n;
    pt = p;
    in_valid_v[k] = 1'b1;
    #1;
    check({tag, "_in_ready"}, 128'(in_ready_v[k]), 128'(1));
    step();
    in_valid_v[k] = 1'b0;
    n = 1;
    while (!out_valid_v[k] && n < 40) begin
      step();
      n++;
    end
    check({tag, "_latency"}, 128'(n), 128'(lat));
    check({tag, "_ct"}, ct_a[k], e);
    $display("block %s: key_bits=%0d pt=%h ct=%h latency=%0d", tag, 128 + 64 * k, p, ct_a[k], n);
    step();
    check({tag, "_valid_drop"}, 128'(out_valid_v[k]), 128'(0));
  endtask

  logic [127:0] pts  [3];
  logic [127:0] exps [3];
  logic [255:0] key;
  bit           seen;
  int           n;

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1; pt = '0; in_valid_v = '0;

    // Bench S-box from the GF(2^8) inverse plus the affine map.
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] b;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sb[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
    for (int k = 0; k < 3; k++) begin
      key = '0;
      for (int b = 0; b < 4 * (4 + 2 * k); b++) key[255-8*b -: 8] = 8'(b);
      for (int r = 0; r < 16; r++)
        rk_tab[k][r] = (r <= 10 + 2 * k) ? rk_of(4 + 2 * k, key, r) : '0;
    end
    pts[0] = PT0;
    pts[1] = 128'h3243f6a8885a308d313198a2e0370734;
    pts[2] = 128'hffeeddccbbaa99887766554433221100;
    exps[0] = CT128;
    exps[1] = aes_ref(0, pts[1]);
    exps[2] = aes_ref(0, pts[2]);

    // Reset state
    step(); step();
    check("rst_in_ready", 128'(in_ready_v[0]), 128'(1));
    check("rst_out_valid", 128'(out_valid_v[0]), 128'(0));
    check("rst_busy", 128'(busy_v[0]), 128'(0));
    check("rst_rk_idx", 128'(rk_idx_a[0]), 128'(0));
    check("rst_ct", ct_a[0], 128'(0));
    rst = 1'b0;
    step();

    // Known-answer vectors for all three key lengths
    send_block(0, PT0, CT128, 11, "kat128");
    send_block(1, PT0, CT192, 13, "kat192");
    send_block(2, PT0, CT256, 15, "kat256");

    // Backpressure: hold out_ready low in DONE
    out_ready = 1'b0;
    pt = pts[0];
    in_valid_v[0] = 1'b1;
    step();
    in_valid_v[0] = 1'b0;
    n = 1;
    while (!out_valid_v[0] && n < 40) begin step(); n++; end
    check("bp_latency", 128'(n), 128'(11));
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_valid_held", 128'(out_valid_v[0]), 128'(1));
      check("bp_ct_held", ct_a[0], CT128);
      check("bp_in_ready", 128'(in_ready_v[0]), 128'(0));
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 128'(in_ready_v[0]), 128'(1));
    $display("block backpressure: ct=%h released", ct_a[0]);
    step();
    check("bp_handshake", 128'(out_valid_v[0]), 128'(0));
    step();
    check("bp_once", 128'(out_valid_v[0]), 128'(0));

    // Back-to-back: in_valid held high across three blocks
    pt = pts[0];
    in_valid_v[0] = 1'b1;
    step();
    for (int j = 0; j < 3; j++) begin
      pt = pts[(j + 1) % 3];
      if (j == 2) in_valid_v[0] = 1'b0;
      n = 1;
      while (!out_valid_v[0] && n < 40) begin step(); n++; end
      check("b2b_spacing", 128'(n), 128'(11));
      check("b2b_ct", ct_a[0], exps[j]);
      if (j < 2) check("b2b_in_ready", 128'(in_ready_v[0]), 128'(1));
      $display("block b2b%0d: ct=%h spacing=%0d", j, ct_a[0], n);
      step();
    end
    check("b2b_drain", 128'(out_valid_v[0]), 128'(0));

    // Flush in round 5
    pt = pts[1];
    in_valid_v[0] = 1'b1;
    step();
    in_valid_v[0] = 1'b0;
    step(); step(); step(); step();
    check("fl_rk_idx5", 128'(rk_idx_a[0]), 128'(5));
    flush = 1'b1;
    step();
    check("fl_busy", 128'(busy_v[0]), 128'(0));
    check("fl_rk_idx", 128'(rk_idx_a[0]), 128'(0));
    check("fl_out_valid", 128'(out_valid_v[0]), 128'(0));
    pt = pts[2];
    in_valid_v[0] = 1'b1;
    #1;
    check("fl_in_ready", 128'(in_ready_v[0]), 128'(0));
    step();
    check("fl_no_accept", 128'(busy_v[0]), 128'(0));
    in_valid_v[0] = 1'b0;
    flush = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (out_valid_v[0]) seen = 1'b1;
    end
    check("fl_no_output", 128'(seen), 128'(0));
    $display("block flushed: pt=%h discarded", pts[1]);
    send_block(0, pts[2], exps[2], 11, "post_flush");

    // Asynchronous reset mid-round
    pt = pts[1];
    in_valid_v[0] = 1'b1;
    step();
    in_valid_v[0] = 1'b0;
    step(); step();
    #2;
    rst = 1'b1;
    #1;
    check("ar_in_ready", 128'(in_ready_v[0]), 128'(1));
    check("ar_out_valid", 128'(out_valid_v[0]), 128'(0));
    check("ar_busy", 128'(busy_v[0]), 128'(0));
    check("ar_rk_idx", 128'(rk_idx_a[0]), 128'(0));
    check("ar_ct", ct_a[0], 128'(0));
    $display("block reset: pt=%h discarded", pts[1]);
    #2;
    rst = 1'b0;
    step();
    send_block(0, pts[1], exps[1], 11, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
